// File: rtl/serdes_pkg.sv
// Shared definitions for both ends of the serial link: receiver FSM states,
// frame line levels and the parity helper used when building/checking frames.
package serdes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam logic START_BIT  = 1'b1;
    localparam logic STOP_BIT   = 1'b0;
    localparam logic IDLE_LEVEL = 1'b0;

    localparam int PARITY_MAX_W = 64;

    // Returns the bit that makes data plus that bit have even parity.
    // Callers zero-extend narrower words, which leaves the result unchanged.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO. The head word is kept in its own register so
// it holds the last value seen once the FIFO drains.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int COUNT_W   = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic [COUNT_W-1:0]    count
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [COUNT_W-1:0]    count_reg, count_next;
    logic [DATA_WIDTH-1:0] head_reg, head_next;
    logic                  do_push, do_pop;

    always_comb begin
        do_pop      = pop && (count_reg != '0);
        do_push     = push && ((count_reg != COUNT_W'(FIFO_DEPTH)) || do_pop);
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
        count_next  = count_reg + COUNT_W'(do_push) - COUNT_W'(do_pop);
        head_next   = head_reg;
        // If nothing older survives this cycle, the incoming word becomes the head
        // directly, since it is not in the array yet.
        if (count_next != '0) begin
            if ((count_reg - COUNT_W'(do_pop)) == '0) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(do_push);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

    assign head  = head_reg;
    assign count = count_reg;

endmodule

// File: rtl/serdes_rx.sv
// Serial link receiver: deframes start/data/parity/stop frames into words,
// drops bad frames with sticky error flags, and buffers good words in a FIFO.
module serdes_rx
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  overflow_err,
    input  logic                  err_clear
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int COUNT_W   = $clog2(FIFO_DEPTH) + 1;

    rx_state_e             state_reg, state_next;
    logic [BIT_CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic                  parity_bit_reg, parity_bit_next;
    logic                  parity_err_reg, framing_err_reg, overflow_err_reg;
    logic                  push, pop, parity_ok;
    logic                  parity_set, framing_set, overflow_set;
    logic [COUNT_W-1:0]    fifo_count;

    // Each data bit lands directly in its own slot rather than being shifted through.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_capture
            assign shift_next[gi] = (state_reg == DATA && bit_cnt_reg == BIT_CNT_W'(gi))
                                    ? serial_in : shift_reg[gi];
        end
    endgenerate

    assign parity_ok = !PARITY_EN
                       || (even_parity(PARITY_MAX_W'(shift_reg)) == parity_bit_reg);

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        parity_bit_next = parity_bit_reg;
        push            = 1'b0;
        parity_set      = 1'b0;
        framing_set     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (serial_in == START_BIT) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                    state_next = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                parity_bit_next = serial_in;
                state_next      = STOP;
            end
            STOP: begin
                if (serial_in == STOP_BIT) begin
                    state_next = IDLE;
                    if (parity_ok) begin
                        push = 1'b1;
                    end else begin
                        parity_set = 1'b1;
                    end
                end else begin
                    // A high stop bit means we lost alignment; wait for the line to idle.
                    framing_set = 1'b1;
                    state_next  = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (serial_in == IDLE_LEVEL) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign valid_out    = (fifo_count != '0);
    assign pop          = valid_out && ready_in;
    assign overflow_set = push && (fifo_count == COUNT_W'(FIFO_DEPTH)) && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            shift_reg        <= '0;
            parity_bit_reg   <= 1'b0;
            parity_err_reg   <= 1'b0;
            framing_err_reg  <= 1'b0;
            overflow_err_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            bit_cnt_reg      <= bit_cnt_next;
            shift_reg        <= shift_next;
            parity_bit_reg   <= parity_bit_next;
            parity_err_reg   <= parity_set   || (parity_err_reg   && !err_clear);
            framing_err_reg  <= framing_set  || (framing_err_reg  && !err_clear);
            overflow_err_reg <= overflow_set || (overflow_err_reg && !err_clear);
        end
    end

    sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_data(shift_reg),
        .pop      (pop),
        .head     (parallel_out),
        .count    (fifo_count)
    );

    assign parity_err   = parity_err_reg;
    assign framing_err  = framing_err_reg;
    assign overflow_err = overflow_err_reg;

endmodule

// File: doc/serdes_rx.md
Name: serdes_rx

Overview:
Receive end of the team's serial link. Takes a framed, one-bit-per-clock serial stream and deframes it back into DATA_WIDTH-bit words. Checks parity and stop bit, then buffers good words in an output FIFO. Presents words on a valid/ready parallel interface that matches the parallel side of the serdes path. Sits at the far end of the link, feeding the downstream consumer of parallel words.

Parameters:
DATA_WIDTH, 8, payload bits per frame
FIFO_DEPTH, 4, output buffer entries; power of two, >= 2
PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  reset; synchronous, active-low
serial_in  input  1  serial line; idles at 0; one bit per clk
parallel_out  output  DATA_WIDTH  head-of-FIFO word
valid_out  output  1  parallel_out holds a valid word
ready_in  input  1  consumer accepts the word; pop occurs when valid_out && ready_in
parity_err  output  1  sticky: a frame was dropped for bad parity
framing_err  output  1  sticky: a frame was dropped for a bad stop bit
overflow_err  output  1  sticky: a good frame was dropped because the FIFO was full
err_clear  input  1  clears all three sticky flags

Behaviour:
- Frame format: start bit (1), then DATA_WIDTH data bits LSB first, then parity bit if PARITY_EN, then stop bit (0). Even parity: XOR of the data bits and the parity bit must be 0.
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; bit counter, shift register and FIFO pointers/count go to 0.
  - valid_out=0, parallel_out=0, all error flags 0.
  - Reset mid-frame abandons the partial frame; nothing is pushed.
- FSM states: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: serial_in=1 -> DATA with bit_cnt=0; otherwise stay.
  - DATA: shift serial_in into bit bit_cnt each cycle. After bit DATA_WIDTH-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: latch the parity bit -> STOP.
  - STOP, serial_in=0 and parity ok: push the word (subject to the FIFO rule below) -> IDLE.
  - STOP, serial_in=0 and parity bad: drop the word, set parity_err -> IDLE.
  - STOP, serial_in=1: drop the word, set framing_err -> WAIT_IDLE. The parity check is not applied to this frame.
  - WAIT_IDLE: stay while serial_in=1; serial_in=0 -> IDLE. A held-high line is never taken as a new start bit.
- Back-to-back frames: a start bit in the cycle immediately after STOP is accepted, with no idle gap required.
- Latency:
  - Frame length is 2 + DATA_WIDTH + PARITY_EN cycles.
  - The pushed word appears on parallel_out with valid_out=1 in the cycle after the STOP cycle, when the FIFO was empty.
- FIFO:
  - First-word-fall-through: parallel_out always shows the head entry; valid_out = (count != 0).
  - Push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow_err is set.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - parallel_out holds its last value while empty.
- Error flags: set in the cycle after the event and held until err_clear=1. If err_clear and a set event occur in the same cycle, set wins.

Decomposition:
- Shared package serdes_pkg holds:
  - rx_state_e enum (IDLE, DATA, PARITY, STOP, WAIT_IDLE);
  - the frame constants START_BIT=1, STOP_BIT=0, IDLE_LEVEL=0;
  - an even-parity function, reused by the transmit side.
- One sub-module, sync_fifo (DATA_WIDTH, FIFO_DEPTH), a first-word-fall-through FIFO with push/pop/count.
- The deframing FSM and error flags live in serdes_rx.

Test Plan:
- Single frame, DATA_WIDTH=8, PARITY_EN=1, ready_in=1: serial 1, 1,0,1,0,0,1,0,1, 0, 0 (0xA5) -> valid_out=1 for exactly one cycle, the cycle after the stop bit, with parallel_out=0xA5; all error flags 0.
- Parity error: frame for 0x3C with parity bit 1 -> valid_out stays 0, parity_err=1 and held. Then pulse err_clear -> parity_err=0 next cycle.
- Framing error: frame for 0x01 with stop bit 1, then line held at 1 for 3 cycles, then 0 -> no push, framing_err=1, FSM stays in WAIT_IDLE until the line goes 0. A following 0x02 frame is received correctly.
- Backpressure/overflow, FIFO_DEPTH=4, ready_in=0: send 0x10..0x14 back-to-back -> 0x14 dropped, overflow_err=1. Raise ready_in -> 0x10, 0x11, 0x12, 0x13 pop on consecutive cycles, then valid_out=0.
- Full plus simultaneous pop: FIFO holds 4 words, ready_in=1 during the STOP cycle of 0x20 -> 0x20 accepted, count stays 4, overflow_err stays 0.
- Reset mid-frame: rst_n=0 for 1 cycle during data bit 4 -> after release, no valid_out and flags 0. The next frame 0x5A is received intact.
